// File: rtl/gate_test_sequencer_if.sv
// Control/observe bundle between a start/abort source, the sequencer and the gate under test.
// The master side is the controller/bench; the slave side is the sequencer.
interface gate_test_sequencer_if;
    logic       start;
    logic       abort;
    logic       dut_out;
    logic       inA;
    logic       inB;
    logic       busy;
    logic       done;
    logic       pass;
    logic [2:0] err_count;
    logic [3:0] fail_mask;

    modport master (
        output start, abort, dut_out,
        input  inA, inB, busy, done, pass, err_count, fail_mask
    );

    modport slave (
        input  start, abort, dut_out,
        output inA, inB, busy, done, pass, err_count, fail_mask
    );
endinterface

// File: rtl/gate_test_sequencer.sv
// Walks the four input vectors of a 2-input gate, waits SETTLE_CYCLES, samples the output
// and compares it against TRUTH; reports per-vector fail flags, error count and pass/done.
//
// state  | meaning
// IDLE   | waiting for start, gate inputs parked at 00
// SETTLE | current vector driven, counting down the settle time
// CHECK  | sampling dut_out at the edge that ends this cycle
// DONE   | results held, start re-runs
module gate_test_sequencer #(
    parameter int         SETTLE_CYCLES = 1,
    parameter logic [3:0] TRUTH         = 4'b0111
) (
    input logic                  clk,
    input logic                  rst,
    gate_test_sequencer_if.slave bus
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETTLE = 2'd1;
    localparam logic [1:0] S_CHECK  = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    localparam logic [7:0] CNT_LOAD = 8'(SETTLE_CYCLES - 1);

    logic [1:0] state_q, state_d;
    logic [1:0] idx_q, idx_d;
    logic [7:0] cnt_q, cnt_d;
    logic       inA_q, inA_d;
    logic       inB_q, inB_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       pass_q, pass_d;
    logic [2:0] err_q, err_d;
    logic [3:0] fail_q, fail_d;
    logic       mismatch;

    // Written so an X/Z on dut_out falls through to "mismatch" in simulation.
    always_comb begin
        mismatch = 1'b1;
        if (bus.dut_out == TRUTH[idx_q]) begin
            mismatch = 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        inA_d   = inA_q;
        inB_d   = inB_q;
        busy_d  = busy_q;
        done_d  = done_q;
        pass_d  = pass_q;
        err_d   = err_q;
        fail_d  = fail_q;

        if (state_q != S_IDLE && bus.abort) begin
            // Partial results stay visible after an abort.
            state_d = S_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b0;
            pass_d  = 1'b0;
            inA_d   = 1'b0;
            inB_d   = 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        state_d = S_SETTLE;
                        idx_d   = 2'd0;
                        cnt_d   = CNT_LOAD;
                        inA_d   = 1'b0;
                        inB_d   = 1'b0;
                        busy_d  = 1'b1;
                        done_d  = 1'b0;
                        pass_d  = 1'b0;
                        err_d   = 3'd0;
                        fail_d  = 4'd0;
                    end
                end
                S_SETTLE: begin
                    if (cnt_q == 8'd0) begin
                        state_d = S_CHECK;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
                S_CHECK: begin
                    err_d  = err_q + {2'b00, mismatch};
                    fail_d = fail_q | ({3'b000, mismatch} << idx_q);
                    if (idx_q == 2'd3) begin
                        state_d = S_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = (err_d == 3'd0);
                        inA_d   = 1'b0;
                        inB_d   = 1'b0;
                    end else begin
                        state_d = S_SETTLE;
                        idx_d   = idx_q + 2'd1;
                        cnt_d   = CNT_LOAD;
                        inA_d   = idx_d[0];
                        inB_d   = idx_d[1];
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= 2'd0;
            cnt_q   <= 8'd0;
            inA_q   <= 1'b0;
            inB_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= 3'd0;
            fail_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            inA_q   <= inA_d;
            inB_q   <= inB_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
            fail_q  <= fail_d;
        end
    end

    assign bus.inA       = inA_q;
    assign bus.inB       = inB_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.pass      = pass_q;
    assign bus.err_count = err_q;
    assign bus.fail_mask = fail_q;

endmodule
